// File: rtl/sift_lb_pkg.sv
// Shared defaults and width helpers for the line-buffer window block.
package sift_lb_pkg;

    localparam int LB_DW    = 16;
    localparam int LB_TAPS  = 5;
    localparam int LB_MAX_W = 160;
    localparam int LB_LW    = $clog2(LB_MAX_W + 1);
    localparam int LB_CW    = $clog2(LB_MAX_W);

    // Zero or over-long line lengths fall back to the full RAM depth.
    function automatic int unsigned lb_clamp(input int unsigned w, input int unsigned max_w);
        return (w == 0 || w > max_w) ? max_w : w;
    endfunction

endpackage

// File: rtl/line_ram_delay.sv
// One line stage: circular RAM, read old pixel and write new pixel at the shared column pointer.
// Latency: combinational read, write on the clock edge; no backpressure, writes follow we.
module line_ram_delay
    import sift_lb_pkg::*;
#(
    parameter int DW    = LB_DW,
    parameter int DEPTH = LB_MAX_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buff_win.sv
// Line buffer producing a TAPS-high pixel column per input beat; LINE_BUFF_BORDER_EN enables top-edge replication.
// Latency: outputs registered one cycle after the valid_in beat.
// Backpressure: none; idle cycles (valid_in low) freeze all state.
module line_buff_win
    import sift_lb_pkg::*;
#(
    parameter int DW    = LB_DW,
    parameter int TAPS  = LB_TAPS,
    parameter int MAX_W = LB_MAX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sof,
    input  logic [$clog2(MAX_W+1)-1:0] line_w,
    input  logic                       valid_in,
    input  logic [DW-1:0]              data_in,
    output logic                       valid_out,
    output logic [TAPS*DW-1:0]         data_out,
    output logic [$clog2(MAX_W)-1:0]   col_out,
    output logic                       eol_out
);

    localparam int LW = $clog2(MAX_W + 1);
    localparam int CW = $clog2(MAX_W);
    localparam int RW = $clog2(TAPS);

    logic [CW-1:0]      col_q, col_cur, col_nxt;
    logic [RW-1:0]      row_q, row_cur, row_nxt;
    logic [LW-1:0]      lw_q, lw_cur;
    logic               active_q;
    logic               last;
    logic               out_vld;
    logic [DW-1:0]      tap [TAPS];
    logic [TAPS*DW-1:0] win;

    // A sof beat overrides the running counters so its pixel lands at (0,0).
    always_comb begin
        col_cur = sof ? '0 : col_q;
        row_cur = sof ? '0 : row_q;
        lw_cur  = sof ? LW'(lb_clamp({{(32-LW){1'b0}}, line_w}, MAX_W)) : lw_q;
        last    = (LW'(col_cur) == lw_cur - LW'(1));
        col_nxt = last ? '0 : col_cur + CW'(1);
        row_nxt = row_cur;
        if (last && row_cur != RW'(TAPS - 1)) begin
            row_nxt = row_cur + RW'(1);
        end
    end

    assign tap[0] = data_in;

    for (genvar s = 1; s < TAPS; s++) begin : g_stage
        line_ram_delay #(
            .DW    (DW),
            .DEPTH (MAX_W),
            .AW    (CW)
        ) u_stage (
            .clk   (clk),
            .we    (valid_in),
            .addr  (col_cur),
            .wdata (tap[s-1]),
            .rdata (tap[s])
        );
    end

    always_comb begin
        win = '0;
        for (int k = 0; k < TAPS; k++) begin
`ifdef LINE_BUFF_BORDER_EN
            win[k*DW +: DW] = (k > int'(row_cur)) ? tap[row_cur] : tap[k];
`else
            win[k*DW +: DW] = tap[k];
`endif
        end
    end

    // Stale RAM lines are hidden by the row counter; after reset only a sof reopens output.
    always_comb begin
`ifdef LINE_BUFF_BORDER_EN
        out_vld = valid_in && (active_q || sof);
`else
        out_vld = valid_in && (active_q || sof) && (row_cur == RW'(TAPS - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            lw_q      <= LW'(MAX_W);
            active_q  <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
            col_out   <= '0;
            eol_out   <= 1'b0;
        end else begin
            valid_out <= out_vld;
            eol_out   <= out_vld && last;
            if (valid_in) begin
                col_q <= col_nxt;
                row_q <= row_nxt;
                lw_q  <= lw_cur;
                if (sof) begin
                    active_q <= 1'b1;
                end
            end
            if (out_vld) begin
                data_out <= win;
                col_out  <= col_cur;
            end
        end
    end

endmodule
